// File: rtl/btn_pkg.sv
// btn_pkg: definitions shared by the button input path.
//   - 2-bit FSM state encodings for the event decoder
//   - integer helpers used to size the hold/repeat counter
// Callers of btn_debouncer reuse the same helpers for their own cycle counts.
package btn_pkg;

    // Decoder FSM states.
    localparam logic [1:0] ST_WAIT_IDLE = 2'd0;  // waiting for first release after reset
    localparam logic [1:0] ST_IDLE      = 2'd1;  // released, armed for a press
    localparam logic [1:0] ST_PRESSED   = 2'd2;  // held, below the long-press threshold
    localparam logic [1:0] ST_REPEAT    = 2'd3;  // held past the long-press threshold

    // Larger of two integers.
    function automatic int max_int(input int a, input int b);
        if (a > b) begin
            return a;
        end else begin
            return b;
        end
    endfunction

    // Bits needed by a counter that must represent 0 .. max(long, rep).
    function automatic int cnt_width(input int long_cycles, input int rep_cycles);
        return $clog2(max_int(long_cycles, rep_cycles) + 1);
    endfunction

endpackage

// File: rtl/btn_event_decoder.sv
// btn_event_decoder: turns a debounced, synchronous button level
// (1 = released, 0 = pressed) into single-cycle user-input events.
//
// Ports:
//   clk          in   system clock
//   reset        in   asynchronous, active-high reset
//   btnLevel     in   debounced button level, synchronous to clk
//   pressPulse   out  one-cycle pulse after a press is sampled
//   releasePulse out  one-cycle pulse after any release
//   shortPress   out  one-cycle pulse on release before the long threshold
//   longPress    out  one-cycle pulse when the hold reaches LONG_CYCLES
//   repeatPulse  out  one-cycle pulse every REPEAT_CYCLES after longPress
//   held         out  high while the FSM is in PRESSED or REPEAT
// All outputs are registered.
module btn_event_decoder
    import btn_pkg::*;
#(
    parameter int  CLKIN_FREQ        = 27_000_000,
    parameter real LONG_PRESS_PERIOD = 0.5,
    parameter real REPEAT_PERIOD     = 0.1,
    parameter bit  REPEAT_EN         = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic btnLevel,
    output logic pressPulse,
    output logic releasePulse,
    output logic shortPress,
    output logic longPress,
    output logic repeatPulse,
    output logic held
);

    // Periods are rounded to the nearest whole cycle so that values such as
    // 1000 * 0.01 cannot truncate to one cycle short.
    localparam int LONG_CYCLES   = $rtoi(real'(CLKIN_FREQ) * LONG_PRESS_PERIOD + 0.5);
    localparam int REPEAT_CYCLES = $rtoi(real'(CLKIN_FREQ) * REPEAT_PERIOD + 0.5);
    localparam int CW            = cnt_width(LONG_CYCLES, REPEAT_CYCLES);

    localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYCLES - 1);
    localparam logic [CW-1:0] REP_LAST  = CW'(REPEAT_CYCLES - 1);

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          press_q, press_d;
    logic          release_q, release_d;
    logic          short_q, short_d;
    logic          long_q, long_d;
    logic          repeat_q, repeat_d;
    logic          held_q, held_d;

    // Next-state logic: FSM, hold counter and event pulses decided together.
    // A release always takes priority over a threshold match on the same edge.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        short_d   = 1'b0;
        long_d    = 1'b0;
        repeat_d  = 1'b0;

        case (state_q)
            ST_WAIT_IDLE: begin
                // A button held through reset must be released before it can press.
                if (btnLevel) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WAIT_IDLE;
                end
                cnt_d = '0;
            end

            ST_IDLE: begin
                if (!btnLevel) begin
                    state_d = ST_PRESSED;
                    press_d = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
                cnt_d = '0;
            end

            ST_PRESSED: begin
                if (btnLevel) begin
                    state_d   = ST_IDLE;
                    release_d = 1'b1;
                    short_d   = 1'b1;
                    cnt_d     = '0;
                end else if (cnt_q == LONG_LAST) begin
                    state_d = ST_REPEAT;
                    long_d  = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            ST_REPEAT: begin
                if (btnLevel) begin
                    state_d   = ST_IDLE;
                    release_d = 1'b1;
                    cnt_d     = '0;
                end else if (REPEAT_EN) begin
                    if (cnt_q == REP_LAST) begin
                        repeat_d = 1'b1;
                        cnt_d    = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end else begin
                    cnt_d = '0;
                end
            end

            default: begin
                state_d = ST_WAIT_IDLE;
                cnt_d   = '0;
            end
        endcase

        // held tracks the state being entered, so it drops with releasePulse.
        held_d = (state_d == ST_PRESSED) || (state_d == ST_REPEAT);
    end

    // State, counter and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_WAIT_IDLE;
            cnt_q     <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            short_q   <= 1'b0;
            long_q    <= 1'b0;
            repeat_q  <= 1'b0;
            held_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            press_q   <= press_d;
            release_q <= release_d;
            short_q   <= short_d;
            long_q    <= long_d;
            repeat_q  <= repeat_d;
            held_q    <= held_d;
        end
    end

    assign pressPulse   = press_q;
    assign releasePulse = release_q;
    assign shortPress   = short_q;
    assign longPress    = long_q;
    assign repeatPulse  = repeat_q;
    assign held         = held_q;

endmodule

// File: tb/tb_btn_event_decoder.sv
// Scoreboard bench for btn_event_decoder.
// Clock 1000 Hz nominal: long press = 10 cycles, repeat = 4 cycles.
// Events are tagged with the clock edge that produced them; the monitor
// samples on the falling edge, where cyc equals that edge's number.
module tb_btn_event_decoder;

    // Event vector bit order: press, release, short, long, repeat.
    localparam logic [4:0] EV_PRESS = 5'b10000;
    localparam logic [4:0] EV_REL   = 5'b01000;
    localparam logic [4:0] EV_SHORT = 5'b01100;
    localparam logic [4:0] EV_LONG  = 5'b00010;
    localparam logic [4:0] EV_REP   = 5'b00001;

    typedef struct {
        int         at;
        logic [4:0] ev;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    logic btn, btn2;
    logic press1, rel1, short1, long1, rep1, held1;
    logic press2, rel2, short2, long2, rep2, held2;

    int cyc = 0;
    int chk_cnt = 0;
    int pass_cnt = 0;
    int p;
    exp_t q1[$];
    exp_t q2[$];

    btn_event_decoder #(
        .CLKIN_FREQ(1000), .LONG_PRESS_PERIOD(0.01),
        .REPEAT_PERIOD(0.004), .REPEAT_EN(1'b1)
    ) dut (
        .clk(clk), .reset(reset), .btnLevel(btn),
        .pressPulse(press1), .releasePulse(rel1), .shortPress(short1),
        .longPress(long1), .repeatPulse(rep1), .held(held1)
    );

    btn_event_decoder #(
        .CLKIN_FREQ(1000), .LONG_PRESS_PERIOD(0.01),
        .REPEAT_PERIOD(0.004), .REPEAT_EN(1'b0)
    ) dut_norep (
        .clk(clk), .reset(reset), .btnLevel(btn2),
        .pressPulse(press2), .releasePulse(rel2), .shortPress(short2),
        .longPress(long2), .repeatPulse(rep2), .held(held2)
    );

    always #5 clk = ~clk;

    // Edge counter.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        chk_cnt++;
        if (act === exp_v) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp_v, cyc);
        end
    endtask

    task automatic push1(input int at, input logic [4:0] ev);
        exp_t x;
        x.at = at;
        x.ev = ev;
        q1.push_back(x);
    endtask

    task automatic push2(input int at, input logic [4:0] ev);
        exp_t x;
        x.at = at;
        x.ev = ev;
        q2.push_back(x);
    endtask

    // Monitor: every observed pulse must match the next expected event.
    always @(negedge clk) begin
        logic [4:0] ev1, ev2;
        exp_t x;
        ev1 = {press1, rel1, short1, long1, rep1};
        ev2 = {press2, rel2, short2, long2, rep2};
        if (ev1 != 5'b0) begin
            if (q1.size() == 0) begin
                chk_cnt++;
                $display("FAIL dut unexpected event: got %b at edge %0d, expected none", ev1, cyc);
            end else begin
                x = q1.pop_front();
                chk("dut event {edge,ev}", {27'd0, cyc, ev1}, {27'd0, x.at, x.ev});
            end
        end
        if (ev2 != 5'b0) begin
            if (q2.size() == 0) begin
                chk_cnt++;
                $display("FAIL norep unexpected event: got %b at edge %0d, expected none", ev2, cyc);
            end else begin
                x = q2.pop_front();
                chk("norep event {edge,ev}", {27'd0, cyc, ev2}, {27'd0, x.at, x.ev});
            end
        end
    end

    initial begin
        reset = 1'b1;
        btn   = 1'b1;
        btn2  = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset outputs", {58'd0, press1, rel1, short1, long1, rep1, held1}, 64'd0);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        // 1: short press of 4 edges.
        btn = 1'b0;
        p = cyc + 1;
        push1(p, EV_PRESS);
        push1(p + 4, EV_SHORT);
        @(negedge clk);
        chk("held after press", {63'd0, held1}, 64'd1);
        repeat (3) @(negedge clk);
        chk("held before release", {63'd0, held1}, 64'd1);
        btn = 1'b1;
        @(negedge clk);
        chk("held after release", {63'd0, held1}, 64'd0);
        repeat (3) @(negedge clk);

        // 2: long hold with repeats; release coincides with a repeat match.
        btn = 1'b0;
        p = cyc + 1;
        push1(p, EV_PRESS);
        push1(p + 10, EV_LONG);
        push1(p + 14, EV_REP);
        push1(p + 18, EV_REP);
        push1(p + 22, EV_REL);
        repeat (22) @(negedge clk);
        chk("held in repeat", {63'd0, held1}, 64'd1);
        btn = 1'b1;
        repeat (3) @(negedge clk);

        // 3: release exactly on the long-press threshold edge.
        btn = 1'b0;
        p = cyc + 1;
        push1(p, EV_PRESS);
        push1(p + 10, EV_SHORT);
        repeat (10) @(negedge clk);
        btn = 1'b1;
        repeat (3) @(negedge clk);

        // 4: button held low across reset, then released and pressed.
        reset = 1'b1;
        btn   = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        repeat (30) @(negedge clk);
        chk("held while stuck low after reset", {63'd0, held1}, 64'd0);
        btn = 1'b1;
        @(negedge clk);
        btn = 1'b0;
        p = cyc + 1;
        push1(p, EV_PRESS);
        push1(p + 3, EV_SHORT);
        @(negedge clk);
        chk("held after first real press", {63'd0, held1}, 64'd1);
        repeat (2) @(negedge clk);
        btn = 1'b1;
        repeat (3) @(negedge clk);

        // 5: asynchronous reset while in REPEAT.
        btn = 1'b0;
        p = cyc + 1;
        push1(p, EV_PRESS);
        push1(p + 10, EV_LONG);
        repeat (14) @(negedge clk);
        chk("held before async reset", {63'd0, held1}, 64'd1);
        #2 reset = 1'b1;
        #1 chk("outputs during async reset",
               {58'd0, press1, rel1, short1, long1, rep1, held1}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        chk("held after reset, still low", {63'd0, held1}, 64'd0);
        btn = 1'b1;
        @(negedge clk);
        btn = 1'b0;
        p = cyc + 1;
        push1(p, EV_PRESS);
        push1(p + 2, EV_SHORT);
        repeat (2) @(negedge clk);
        btn = 1'b1;
        repeat (3) @(negedge clk);

        // 6: auto-repeat disabled, 40-edge hold.
        btn2 = 1'b0;
        p = cyc + 1;
        push2(p, EV_PRESS);
        push2(p + 10, EV_LONG);
        push2(p + 40, EV_REL);
        repeat (25) @(negedge clk);
        chk("norep held", {63'd0, held2}, 64'd1);
        repeat (15) @(negedge clk);
        btn2 = 1'b1;
        repeat (4) @(negedge clk);

        // Every expected event must have been observed.
        chk("dut events outstanding", 64'(q1.size()), 64'd0);
        chk("norep events outstanding", 64'(q2.size()), 64'd0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
